// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//
// Turns the one-cycle step-rate tick from the prescaled timer into STEP/DIR
// signals for a stepper motor driver. A move command (direction plus step
// count) is taken over a valid/ready handshake. Each accepted tick produces one
// STEP pulse that is PULSE_W cycles wide. When the direction changes, DIR is
// held stable for DIR_SETUP cycles before the first STEP can rise. The block
// tracks a signed absolute position and pulses done for one cycle when a move
// finishes or is aborted.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick       in   step-rate strobe, one cycle wide
//   cmd_valid  in   move command valid
//   cmd_ready  out  command can be accepted (idle)
//   cmd_dir    in   0 = forward (+1), 1 = reverse (-1)
//   cmd_steps  in   number of steps to emit (unsigned)
//   abort      in   stop the move at the next safe point
//   step       out  STEP to motor driver, registered
//   dir        out  DIR to motor driver, registered
//   busy       out  move in progress
//   done       out  one-cycle pulse when a move completes or is aborted
//   position   out  signed step position, wraps modulo 2^POS_W
// -----------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int CNT_W     = 16,
    parameter int POS_W     = 32,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    abort,
    output logic                    step,
    output logic                    dir,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
);

    // One shared down-counter times both the DIR setup wait and the STEP
    // high time, so it is sized for the longer of the two.
    localparam int TMAX  = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_TICK,
        PULSE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [TMR_W-1:0]   timer;
    logic               abort_pend;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            timer      <= '0;
            abort_pend <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is ignored here: there is nothing to stop.
                    if (cmd_valid) begin
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining  <= cmd_steps;
                            abort_pend <= 1'b0;
                            if (cmd_dir != dir) begin
                                dir   <= cmd_dir;
                                timer <= SETUP_LOAD;
                                state <= SETUP;
                            end else begin
                                state <= WAIT_TICK;
                            end
                        end
                    end
                end

                SETUP: begin
                    // Ticks arriving while DIR settles are dropped.
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (timer == '0) begin
                        state <= WAIT_TICK;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                WAIT_TICK: begin
                    // abort has priority over a coincident tick.
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (tick) begin
                        step      <= 1'b1;
                        remaining <= remaining - CNT_W'(1);
                        position  <= dir ? position - POS_W'(1)
                                         : position + POS_W'(1);
                        timer     <= PULSE_LOAD;
                        state     <= PULSE;
                    end
                end

                PULSE: begin
                    // The pulse always runs its full width; an abort seen
                    // during it is remembered and honoured at the end.
                    if (timer == '0) begin
                        step <= 1'b0;
                        if (remaining == '0 || abort || abort_pend) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                        if (abort) begin
                            abort_pend <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//
// Self-checking bench for step_pulse_gen. A timestamp-based reference model
// (edge indices at which ticks become eligible and pulses end) predicts every
// output after each rising edge; directed sequences cover reset, forward and
// reverse moves, DIR setup, abort, zero-length moves, dropped ticks and
// position wrap, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

    localparam int CNT_W     = 16;
    localparam int POS_W     = 8;
    localparam int PULSE_W   = 4;
    localparam int DIR_SETUP = 2;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    tick      = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_dir   = 1'b0;
    logic [CNT_W-1:0]        cmd_steps = '0;
    logic                    abort     = 1'b0;
    logic                    cmd_ready;
    logic                    step;
    logic                    dir;
    logic                    busy;
    logic                    done;
    logic signed [POS_W-1:0] position;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int               cyc        = 0;
    bit               m_busy     = 1'b0;
    bit               m_step     = 1'b0;
    bit               m_dir      = 1'b0;
    bit               m_done     = 1'b0;
    logic [POS_W-1:0] m_pos      = '0;
    int               left       = 0;
    int               ok_from    = 0;
    int               pulse_end  = 0;
    bit               abort_req  = 1'b0;
    bit               m_acc      = 1'b0;

    step_pulse_gen #(
        .CNT_W    (CNT_W),
        .POS_W    (POS_W),
        .PULSE_W  (PULSE_W),
        .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_steps(cmd_steps),
        .abort    (abort),
        .step     (step),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("step",      32'(step),                 32'(m_step));
        chk("dir",       32'(dir),                  32'(m_dir));
        chk("busy",      32'(busy),                 32'(m_busy));
        chk("done",      32'(done),                 32'(m_done));
        chk("cmd_ready", 32'(cmd_ready),            32'(!m_busy));
        chk("position",  32'($unsigned(position)),  32'(m_pos));
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_step    = 1'b0;
        m_dir     = 1'b0;
        m_done    = 1'b0;
        m_pos     = '0;
        left      = 0;
        abort_req = 1'b0;
        m_acc     = 1'b0;
    endtask

    // Predicts outputs after one rising edge from the inputs held across it.
    task automatic model_edge();
        cyc++;
        m_done = 1'b0;
        m_acc  = 1'b0;
        if (!m_busy) begin
            if (cmd_valid) begin
                m_acc = 1'b1;
                if (cmd_steps == '0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy    = 1'b1;
                    left      = int'(cmd_steps);
                    abort_req = 1'b0;
                    if (cmd_dir != m_dir) begin
                        m_dir   = cmd_dir;
                        ok_from = cyc + 1 + DIR_SETUP;
                    end else begin
                        ok_from = cyc + 1;
                    end
                end
            end
        end else if (m_step) begin
            if (abort) abort_req = 1'b1;
            if (cyc == pulse_end) begin
                m_step = 1'b0;
                if (left == 0 || abort_req) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    ok_from = cyc + 1;
                end
            end
        end else begin
            if (abort) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else if (tick && cyc >= ok_from) begin
                m_step    = 1'b1;
                left      = left - 1;
                m_pos     = m_dir ? m_pos - 8'd1 : m_pos + 8'd1;
                pulse_end = cyc + PULSE_W;
            end
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare_all();
        if (m_acc) cmd_valid = 1'b0;
        tick  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic issue(input bit d, input int n);
        cmd_dir   = d;
        cmd_steps = CNT_W'(n);
        cmd_valid = 1'b1;
    endtask

    task automatic run_ticks(input int ncyc, input int period, input int phase);
        for (int i = 0; i < ncyc; i++) begin
            tick = (period > 0) && ((i % period) == phase);
            cyc_step();
        end
    endtask

    // Reset asserted between edges: step must drop without waiting for clk.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_step_low", 32'(step), 32'd0);
        model_reset();
        compare_all();
        cyc_step();
        rst_n = 1'b1;
    endtask

    initial begin
        // T1 reset
        rst_n = 1'b0;
        repeat (2) cyc_step();
        rst_n = 1'b1;
        cyc_step();

        // T2 forward move of 3 steps, tick every 6 cycles
        issue(1'b0, 3);
        run_ticks(30, 6, 3);
        chk("t2_pos", 32'($unsigned(position)), 32'd3);

        // T3 direction change, first tick lands in DIR setup and is dropped
        issue(1'b1, 2);
        run_ticks(25, 6, 1);
        chk("t3_pos", 32'($unsigned(position)), 32'd1);

        // T4a abort while waiting for a tick after one step
        issue(1'b0, 5);
        for (int i = 0; i < 40; i++) begin
            tick  = (i % 6) == 3;
            abort = m_busy && !m_step && (left == 4);
            cyc_step();
        end
        chk("t4a_pos", 32'($unsigned(position)), 32'd2);

        // T4b abort in the middle of a pulse
        issue(1'b0, 5);
        for (int i = 0; i < 40; i++) begin
            tick  = (i % 6) == 3;
            abort = m_step && (cyc + 1 == pulse_end - 2);
            cyc_step();
        end
        chk("t4b_pos", 32'($unsigned(position)), 32'd3);

        // T5 zero-length move
        issue(1'b0, 0);
        cyc_step();
        chk("t5_zero_done", 32'(done), 32'd1);
        cyc_step();
        chk("t5_zero_busy", 32'(busy), 32'd0);

        // T5 tick and abort together in WAIT_TICK
        issue(1'b0, 2);
        cyc_step();
        tick  = 1'b1;
        abort = 1'b1;
        cyc_step();
        chk("t5_tick_abort_step", 32'(step), 32'd0);
        cyc_step();

        // T5 ticks too fast: most are dropped
        issue(1'b1, 3);
        run_ticks(40, 2, 0);
        chk("t5_fast_pos", 32'($unsigned(position)), 32'd0);

        // T6 wrap below zero
        do_reset();
        issue(1'b1, 1);
        run_ticks(14, 4, 2);
        chk("t6_wrap", 32'($unsigned(position)), 32'hFF);

        // T6 reset mid-pulse, then a normal command
        issue(1'b1, 3);
        for (int i = 0; i < 12 && !m_step; i++) begin
            tick = 1'b1;
            cyc_step();
        end
        chk("t6_in_pulse", 32'(step), 32'd1);
        do_reset();
        issue(1'b0, 2);
        run_ticks(20, 6, 2);
        chk("t6_after_rst_pos", 32'($unsigned(position)), 32'd2);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            if (!m_busy && !cmd_valid && ($urandom % 4) == 0)
                issue($urandom_range(0, 1) == 1, int'($urandom_range(0, 5)));
            tick  = ($urandom % 4) == 0;
            abort = ($urandom % 50) == 0;
            if (($urandom % 700) == 0) do_reset();
            else cyc_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
